// File: rtl/br_predict_unit_pkg.sv
// Shared constants, types and helpers for the ID-stage branch resolver and its BHT.
package br_predict_unit_pkg;

  localparam logic [5:0] OpBeq    = 6'b000100;
  localparam logic [5:0] OpBne    = 6'b000101;
  localparam logic [5:0] OpBlez   = 6'b000110;
  localparam logic [5:0] OpBgtz   = 6'b000111;
  localparam logic [5:0] OpRegimm = 6'b000001;

  localparam logic [4:0] RtBltz = 5'b00000;
  localparam logic [4:0] RtBgez = 5'b00001;

  typedef logic [1:0] bht_ctr_t;

  // Weakly not-taken.
  localparam bht_ctr_t BhtReset = 2'b01;

  typedef enum logic [2:0] {
    BrNone,
    BrEq,
    BrNe,
    BrLez,
    BrGtz,
    BrLtz,
    BrGez
  } br_kind_t;

  function automatic bht_ctr_t bht_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) nxt = ctr + 2'd1;
    else if (!taken && ctr != 2'b00) nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/br_predict_unit_cond.sv
// Combinational MIPS conditional-branch decoder and condition evaluator.
module br_cond
  import br_predict_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rdata1,
  input  logic [WIDTH-1:0] rdata2,
  output logic             is_br,
  output logic             cond
);

  br_kind_t   kind;
  logic [5:0] opcode;
  logic [4:0] rt;
  logic       a_neg;
  logic       a_zero;

  assign opcode = instr[31:26];
  assign rt     = instr[20:16];

  // Signed tests only need the sign bit and a zero detect, so no subtractor.
  assign a_neg  = rdata1[WIDTH-1];
  assign a_zero = (rdata1 == '0);

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    kind = BrNone;
    unique case (opcode)
      OpBeq:    kind = BrEq;
      OpBne:    kind = BrNe;
      OpBlez:   kind = BrLez;
      OpBgtz:   kind = BrGtz;
      OpRegimm: begin
        if (rt == RtBltz)      kind = BrLtz;
        else if (rt == RtBgez) kind = BrGez;
      end
      default:  kind = BrNone;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    unique case (kind)
      BrEq:    cond = (rdata1 == rdata2);
      BrNe:    cond = (rdata1 != rdata2);
      BrLez:   cond = a_neg | a_zero;
      BrGtz:   cond = ~a_neg & ~a_zero;
      BrLtz:   cond = a_neg;
      BrGez:   cond = ~a_neg;
      default: cond = 1'b0;
    endcase
  end

  assign is_br = (kind != BrNone);

  logic unused_instr;
  assign unused_instr = ^{instr[25:21], instr[15:0]};

endmodule

// File: rtl/br_predict_unit.sv
// ID-stage branch resolver with a 2-bit saturating BHT read in IF, and branch/mispredict statistics.
module br_predict_unit
  import br_predict_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic [31:0]      id_instr,
  input  logic [PC_W-1:0]  id_pc,
  input  logic             id_pred_taken,
  input  logic [WIDTH-1:0] id_rdata1,
  input  logic [WIDTH-1:0] id_rdata2,
  output logic             br_taken,
  output logic             br_mispredict,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  bht_ctr_t         bht_q [BHT_DEPTH];
  bht_ctr_t         bht_d [BHT_DEPTH];
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic             is_br;
  logic             cond;
  logic             resolve;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;

  br_cond #(.WIDTH(WIDTH)) u_cond (
    .instr  (id_instr),
    .rdata1 (id_rdata1),
    .rdata2 (id_rdata2),
    .is_br  (is_br),
    .cond   (cond)
  );

  assign resolve       = id_valid & ~id_stall & is_br;
  assign br_taken      = resolve & cond;
  assign br_mispredict = resolve & (cond != id_pred_taken);

  // Word-aligned PCs: the two low bits carry no index information.
  assign rd_idx = if_pc[IDX_W+1:2];
  assign wr_idx = id_pc[IDX_W+1:2];

  // Read returns the registered value, so a same-index update shows up one cycle later.
  assign if_pred_taken = bht_q[rd_idx][1];

  always_comb begin
    bht_d = bht_q;
    if (resolve) bht_d[wr_idx] = bht_next(bht_q[wr_idx], cond);
  end

  always_comb begin
    br_cnt_d   = br_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (resolve && br_cnt_q != '1)         br_cnt_d   = br_cnt_q + 1'b1;
    if (br_mispredict && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // NOTE: the table must come out of reset as weakly not-taken, so it is built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= BhtReset;
    end else begin
      bht_q <= bht_d;
    end
  end

  assign br_cnt   = br_cnt_q;
  assign miss_cnt = miss_cnt_q;

  logic unused_pc;
  assign unused_pc = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0], id_pc[PC_W-1:IDX_W+2], id_pc[1:0]};

endmodule

// File: tb/tb_br_predict_unit.sv
// Scoreboard bench for br_predict_unit: the driver queues expectations, a negedge monitor compares.
module tb_br_predict_unit;
  import br_predict_unit_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   if_pc;
  logic          if_pred_taken;
  logic          id_valid;
  logic          id_stall;
  logic [31:0]   id_instr;
  logic [31:0]   id_pc;
  logic          id_pred_taken;
  logic [31:0]   id_rdata1;
  logic [31:0]   id_rdata2;
  logic          br_taken;
  logic          br_mispredict;
  logic [CW-1:0] br_cnt;
  logic [CW-1:0] miss_cnt;

  br_predict_unit #(.WIDTH(32), .PC_W(32), .BHT_DEPTH(64), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .id_valid      (id_valid),
    .id_stall      (id_stall),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pred_taken (id_pred_taken),
    .id_rdata1     (id_rdata1),
    .id_rdata2     (id_rdata2),
    .br_taken      (br_taken),
    .br_mispredict (br_mispredict),
    .br_cnt        (br_cnt),
    .miss_cnt      (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            vec;
    logic          taken;
    logic          mis;
    logic          pred;
    logic [CW-1:0] bc;
    logic [CW-1:0] mc;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            vec_id   = 0;
  logic [1:0]    m_bht [64];
  logic [CW-1:0] m_bc;
  logic [CW-1:0] m_mc;

  task automatic check(input string name, input int vec, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s vec=%0d got=%0h expected=%0h", name, vec, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    m_bc = '0;
    m_mc = '0;
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd3, rt, 16'h0010};
  endfunction

  // One ID cycle; is_br and cond are the hand-derived decode results for the vector.
  task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic pred, input logic valid, input logic stall,
                       input logic [31:0] ifpc, input logic is_br, input logic cond);
    exp_t e;
    logic rs;
    logic [5:0] wi;
    @(posedge clk);
    #1;
    id_instr = instr; id_rdata1 = a; id_rdata2 = b; id_pc = pc;
    id_pred_taken = pred; id_valid = valid; id_stall = stall; if_pc = ifpc;
    rs      = valid & ~stall & is_br;
    e.vec   = vec_id++;
    e.taken = rs & cond;
    e.mis   = rs & (cond != pred);
    e.pred  = m_bht[ifpc[7:2]][1];
    e.bc    = m_bc;
    e.mc    = m_mc;
    exp_q.push_back(e);
    if (rs) begin
      wi = pc[7:2];
      if (cond && m_bht[wi] != 2'b11) m_bht[wi] = m_bht[wi] + 2'd1;
      else if (!cond && m_bht[wi] != 2'b00) m_bht[wi] = m_bht[wi] - 2'd1;
      if (m_bc != '1) m_bc = m_bc + 1'b1;
      if (cond != pred && m_mc != '1) m_mc = m_mc + 1'b1;
    end
  endtask

  task automatic idle(input logic [31:0] ifpc);
    drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, ifpc, 1'b0, 1'b0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2;
    reset    = 1'b0;
    id_valid = 1'b0;
    model_reset();
    idle(32'h3000);
    idle(32'h14);
    @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("br_taken",      e.vec, {31'b0, br_taken},      {31'b0, e.taken});
      check("br_mispredict", e.vec, {31'b0, br_mispredict}, {31'b0, e.mis});
      check("if_pred_taken", e.vec, {31'b0, if_pred_taken}, {31'b0, e.pred});
      check("br_cnt",        e.vec, {{(32-CW){1'b0}}, br_cnt},   {{(32-CW){1'b0}}, e.bc});
      check("miss_cnt",      e.vec, {{(32-CW){1'b0}}, miss_cnt}, {{(32-CW){1'b0}}, e.mc});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    if_pc = '0; id_valid = 1'b0; id_stall = 1'b0; id_instr = '0;
    id_pc = '0; id_pred_taken = 1'b0; id_rdata1 = '0; id_rdata2 = '0;
    model_reset();
    idle(32'h0);
    idle(32'h4);
    @(negedge clk);
    #2;
    reset = 1'b1;

    // Reset state across every BHT index.
    for (int i = 0; i < 64; i++) idle(32'(i) << 2);

    // BEQ equal, predicted not-taken: taken + mispredict, bht[0] becomes 10.
    drive(enc(OpBeq, 5'd2), 32'h1234, 32'h1234, 32'h3000, 1'b0, 1'b1, 1'b0, 32'h3000, 1'b1, 1'b1);
    idle(32'h3000);

    // Signed boundaries and decode corners at index 1.
    drive(enc(OpBlez, 5'd0),   32'h8000_0000, 32'h0, 32'h104, 1'b1, 1'b1, 1'b0, 32'h104, 1'b1, 1'b1);
    drive(enc(OpBgtz, 5'd0),   32'h0,         32'h0, 32'h104, 1'b1, 1'b1, 1'b0, 32'h104, 1'b1, 1'b0);
    drive(enc(OpRegimm, RtBltz), 32'hFFFF_FFFF, 32'h0, 32'h104, 1'b0, 1'b1, 1'b0, 32'h104, 1'b1, 1'b1);
    drive(enc(OpRegimm, RtBgez), 32'h0,       32'h0, 32'h104, 1'b0, 1'b1, 1'b0, 32'h104, 1'b1, 1'b1);
    drive(enc(OpRegimm, RtBgez), 32'h8000_0000, 32'h0, 32'h104, 1'b1, 1'b1, 1'b0, 32'h104, 1'b1, 1'b0);
    drive(enc(OpBgtz, 5'd0),   32'h1,         32'h0, 32'h104, 1'b0, 1'b1, 1'b0, 32'h104, 1'b1, 1'b1);
    drive(enc(OpBlez, 5'd0),   32'h1,         32'h0, 32'h104, 1'b0, 1'b1, 1'b0, 32'h104, 1'b1, 1'b0);
    drive(enc(OpRegimm, RtBltz), 32'h0,       32'h0, 32'h104, 1'b1, 1'b1, 1'b0, 32'h104, 1'b1, 1'b0);
    drive(enc(OpBne, 5'd2),    32'h55,        32'h55, 32'h104, 1'b0, 1'b1, 1'b0, 32'h104, 1'b1, 1'b0);
    drive(enc(OpRegimm, 5'b00010), 32'hFFFF_FFFF, 32'h0, 32'h104, 1'b1, 1'b1, 1'b0, 32'h104, 1'b0, 1'b0);
    drive(enc(6'b000000, 5'd0), 32'h1, 32'h1, 32'h104, 1'b1, 1'b1, 1'b0, 32'h104, 1'b0, 1'b0);
    idle(32'h104);

    // Saturation at index 2: 01->10->11->11->11, then not-taken ->10 (still predicts 1), again ->01.
    for (int i = 0; i < 4; i++)
      drive(enc(OpBne, 5'd2), 32'h1, 32'h2, 32'h208, 1'b1, 1'b1, 1'b0, 32'h208, 1'b1, 1'b1);
    drive(enc(OpBne, 5'd2), 32'h2, 32'h2, 32'h208, 1'b1, 1'b1, 1'b0, 32'h208, 1'b1, 1'b0);
    idle(32'h208);
    drive(enc(OpBne, 5'd2), 32'h2, 32'h2, 32'h208, 1'b1, 1'b1, 1'b0, 32'h208, 1'b1, 1'b0);
    idle(32'h208);

    // Stall for three cycles, then release: one resolution only.
    for (int i = 0; i < 3; i++)
      drive(enc(OpBeq, 5'd4), 32'h5, 32'h5, 32'h40C, 1'b0, 1'b1, 1'b1, 32'h40C, 1'b1, 1'b1);
    drive(enc(OpBeq, 5'd4), 32'h5, 32'h5, 32'h40C, 1'b0, 1'b1, 1'b0, 32'h40C, 1'b1, 1'b1);
    idle(32'h40C);

    // Same-index read and update: old value this cycle, new value next cycle.
    drive(enc(OpBeq, 5'd4), 32'h7, 32'h7, 32'h14, 1'b0, 1'b1, 1'b0, 32'h14, 1'b1, 1'b1);
    idle(32'h14);

    // Enough taken branches to pin the 4-bit counters at all-ones.
    for (int i = 0; i < 16; i++)
      drive(enc(OpBeq, 5'd4), 32'h9, 32'h9, 32'h18, 1'b0, 1'b1, 1'b0, 32'h18, 1'b1, 1'b1);
    idle(32'h18);

    // Mid-run reset with a resolving branch in flight, then a full sweep.
    drive(enc(OpBeq, 5'd2), 32'h1, 32'h1, 32'h3000, 1'b0, 1'b1, 1'b0, 32'h3000, 1'b1, 1'b1);
    reset_pulse();
    for (int i = 0; i < 64; i++) idle(32'(i) << 2);
    drive(enc(OpBne, 5'd2), 32'h1, 32'h2, 32'h14, 1'b0, 1'b1, 1'b0, 32'h14, 1'b1, 1'b1);
    idle(32'h14);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0 pending entries", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
